fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction fetch stage of the pipelined RV32I core. Sits directly upstream of the decode stage, whose control ROM consumes opcode/funct3/funct7.
- Owns the fetch PC and issues instruction-memory reads under a request/response handshake.
- Buffers returned instructions in a small FIFO. This decouples memory latency from decode stalls.
- Handles redirects (taken branch/jal/jalr) from execute by flushing and discarding in-flight data.

Parameters:
RESET_PC, 32'h0000_0060, first fetch address after reset
DEPTH, 2, instruction buffer entries; power of 2, >= 2

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
imem_read  out  1  read request; held until imem_resp
imem_address  out  32  request address; stable while imem_read high
imem_rdata  in  32  instruction word, valid when imem_resp=1
imem_resp  in  1  one-cycle response strobe
redirect_valid  in  1  execute-stage PC redirect
redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
id_ready  in  1  decode accepts head instruction this cycle
id_valid  out  1  buffer non-empty
id_pc  out  32  PC of head instruction; 0 when id_valid=0
id_instr  out  32  head instruction; 32'h0000_0013 (NOP) when id_valid=0
id_opcode  out  7  id_instr[6:0], typed rv32i_opcode
id_funct3  out  3  id_instr[14:12]
id_funct7  out  7  id_instr[31:25]

Behaviour:
- Registers:
  - fetch_pc: next address to request.
  - req_addr: drives imem_address.
  - state: one of IDLE, FETCH, DISCARD.
  - FIFO: {pc, instr} entries, with head/tail pointers and count (0..DEPTH).
- Reset (rst=0 at an edge):
  - state=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, count=0, pointers=0.
  - imem_read=0, id_valid=0.
- imem_read = (state != IDLE). imem_address = req_addr.
- IDLE:
  - If count<DEPTH: req_addr<=fetch_pc and go to FETCH. The first request appears one cycle after reset release.
  - Otherwise stay in IDLE.
- FETCH, imem_resp=1 with no redirect:
  - Push {req_addr, imem_rdata}; fetch_pc<=fetch_pc+4 (32-bit wrap).
  - If the post-update count<DEPTH: req_addr<=fetch_pc+4 and stay in FETCH (back-to-back requests, no bubble).
  - Otherwise go to IDLE.
- Request issue rule: a request is only issued when count<DEPTH. Only one request is outstanding at a time, so a response never overflows the FIFO.
- Pop: when id_valid && id_ready, advance head. A push and pop in the same cycle leave count unchanged.
- Redirect (highest priority, any state):
  - Flush FIFO (count=0); any same-cycle pop is ignored.
  - fetch_pc<=redirect_pc & ~3.
  - From IDLE: go to IDLE; FETCH starts next cycle.
  - From FETCH with imem_resp=1: drop the data; req_addr<=target; stay in FETCH.
  - From FETCH with imem_resp=0: go to DISCARD; req_addr is unchanged so the bus stays stable.
  - From DISCARD: stay in DISCARD with the updated target.
- DISCARD:
  - imem_read stays high at the old req_addr.
  - On imem_resp: drop the data; req_addr<=fetch_pc; go to FETCH.
  - Stale data never enters the FIFO.
- id_valid = (count != 0), taken from registered state; no combinational path from imem_resp to id_*.
- Reset mid-request: state returns to IDLE and imem_read drops. A late imem_resp arriving while in IDLE is ignored.

Decomposition:
- Add to the rv32i_types package:
  - fetch_state_t enum {IDLE, FETCH, DISCARD}.
  - NOP_INSTR constant 32'h0000_0013.
- Reuse the existing rv32i_word and rv32i_opcode types.
- One sub-module: fetch_buffer.
  - Parameterised circular FIFO of {pc, instr}.
  - push/pop/flush inputs; head/count outputs; synchronous active-low reset.

Test Plan:
- Reset: rst=0 for 3 cycles -> imem_read=0, id_valid=0, id_instr=0x13. Release -> next cycle imem_read=1, imem_address=0x60.
- Streaming, 1-cycle memory, id_ready=1 -> instructions from 0x60, 0x64, 0x68 emerge in order, one per cycle, with matching id_pc and id_opcode=instr[6:0].
- Backpressure, DEPTH=2, id_ready=0 -> after responses for 0x60 and 0x64, imem_read=0 (IDLE). Raise id_ready -> next request at 0x68, and 0x60 is popped first.
- Redirect to 0x100 while a 3-cycle-latency request to 0x64 is pending -> imem_address holds 0x64 until resp, the data is dropped, the next request is to 0x100, and no id_valid shows the 0x64 word.
- Redirect to 0x100 coincident with imem_resp -> data dropped, next cycle imem_address=0x100, id_valid=0.
- Full buffer with redirect and id_ready=1 in the same cycle -> count=0 the next cycle, no double pop, and fetch resumes at the redirect target.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared RV32I types for the fetch stage (word, opcode, fetch FSM state, NOP).
// Ports: none (package only).
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [1:0] {IDLE, FETCH, DISCARD} fetch_state_t;

   localparam rv32i_word NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the instruction-memory handshake, execute redirect and decode handoff.
// Ports (master = fetch stage view):
//   out imem_read, imem_address          read request and its address
//   in  imem_rdata, imem_resp            returned word and one-cycle response strobe
//   in  redirect_valid, redirect_pc      execute-stage PC redirect
//   in  id_ready                         decode accepts the head instruction
//   out id_valid, id_pc, id_instr        head of the instruction buffer
//   out id_opcode, id_funct3, id_funct7  decoded fields of id_instr
interface fetch_stage_if;
   import rv32i_types::*;

   logic        imem_read;
   rv32i_word   imem_address;
   rv32i_word   imem_rdata;
   logic        imem_resp;
   logic        redirect_valid;
   rv32i_word   redirect_pc;
   logic        id_ready;
   logic        id_valid;
   rv32i_word   id_pc;
   rv32i_word   id_instr;
   rv32i_opcode id_opcode;
   logic [2:0]  id_funct3;
   logic [6:0]  id_funct7;

   modport master (
      output imem_read, imem_address, id_valid, id_pc, id_instr, id_opcode, id_funct3, id_funct7,
      input  imem_rdata, imem_resp, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_read, imem_address, id_valid, id_pc, id_instr, id_opcode, id_funct3, id_funct7,
      output imem_rdata, imem_resp, redirect_valid, redirect_pc, id_ready
   );

endinterface

// File: rtl/fetch_stage_buffer.sv
// fetch_buffer: circular FIFO of {pc, instr} pairs between instruction memory and decode.
// Ports:
//   in  clk, rst (sync, active-low)
//   in  push, push_pc, push_instr   write one entry at the tail
//   in  pop                         retire the head entry
//   in  flush                       empty the buffer (wins over push/pop)
//   out head_pc, head_instr         head entry (undefined when count=0)
//   out count                       occupancy 0..DEPTH
module fetch_buffer
   import rv32i_types::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  rv32i_word                  push_pc,
   input  rv32i_word                  push_instr,
   output rv32i_word                  head_pc,
   output rv32i_word                  head_instr,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   rv32i_word        pc_mem    [DEPTH];
   rv32i_word        instr_mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;

   assign head_pc    = pc_mem[head];
   assign head_instr = instr_mem[head];

   // Storage needs no reset: an entry is only read after it has been pushed.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         pc_mem[tail]    <= push_pc;
         instr_mem[tail] <= push_instr;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push)
            tail <= tail + PW'(1);
         if (pop)
            head <= head + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch; owns the fetch PC, issues imem reads and buffers results for decode.
// Ports:
//   in  clk        rising-edge clock
//   in  rst        synchronous reset, active-low
//   bus (master)   imem handshake, redirect input and decode handoff (see fetch_stage_if)
module fetch_stage
   import rv32i_types::*;
#(
   parameter rv32i_word RESET_PC = 32'h0000_0060,
   parameter int        DEPTH    = 2
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);

   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_state_t  state, state_n;
   rv32i_word     fetch_pc, fetch_pc_n;
   rv32i_word     req_addr, req_addr_n;
   rv32i_word     head_pc, head_instr, id_instr, target, pc_inc;
   logic          push, pop, id_valid;
   logic [CW-1:0] count, post_cnt;

   assign target   = bus.redirect_pc & ~32'h3;
   assign pc_inc   = fetch_pc + 32'd4;
   assign id_valid = count != '0;
   // A redirect flushes the buffer, so a same-cycle pop must not also retire the head.
   assign pop      = id_valid && bus.id_ready && !bus.redirect_valid;
   // Occupancy after this cycle's response push; only meaningful in FETCH where count < DEPTH.
   assign post_cnt = count + CW'(1) - CW'(pop);

   fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .flush      (bus.redirect_valid),
      .push_pc    (req_addr),
      .push_instr (bus.imem_rdata),
      .head_pc    (head_pc),
      .head_instr (head_instr),
      .count      (count)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state    <= state_n;
         fetch_pc <= fetch_pc_n;
         req_addr <= req_addr_n;
      end
   end

   // req_addr equals fetch_pc whenever a live (non-discarded) request is in flight,
   // so the pushed PC is simply req_addr.
   always_comb begin
      state_n    = state;
      fetch_pc_n = fetch_pc;
      req_addr_n = req_addr;
      push       = 1'b0;
      if (bus.redirect_valid) begin
         fetch_pc_n = target;
         if (state == FETCH && bus.imem_resp)
            req_addr_n = target;
         else if (state == FETCH)
            state_n = DISCARD;
      end else begin
         case (state)
            IDLE: begin
               if (count < FULL) begin
                  req_addr_n = fetch_pc;
                  state_n    = FETCH;
               end
            end
            FETCH: begin
               if (bus.imem_resp) begin
                  push       = 1'b1;
                  fetch_pc_n = pc_inc;
                  if (post_cnt < FULL)
                     req_addr_n = pc_inc;
                  else
                     state_n = IDLE;
               end
            end
            DISCARD: begin
               if (bus.imem_resp) begin
                  req_addr_n = fetch_pc;
                  state_n    = FETCH;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign id_instr         = id_valid ? head_instr : NOP_INSTR;
   assign bus.imem_read    = state != IDLE;
   assign bus.imem_address = req_addr;
   assign bus.id_valid     = id_valid;
   assign bus.id_pc        = id_valid ? head_pc : '0;
   assign bus.id_instr     = id_instr;
   assign bus.id_opcode    = rv32i_opcode'(id_instr[6:0]);
   assign bus.id_funct3    = id_instr[14:12];
   assign bus.id_funct7    = id_instr[31:25];

endmodule
